// File: rtl/exec_flag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exec_flag_ctrl
// Description : Proof-of-execution flag controller. Tracks one atomic pass
//               through the executable region (ER), raises exec on a clean
//               exit, and latches the abort cause and a saturating abort count.
//               Optional feature macro: VAPE_IRQ_KILL_EN (irq in RUN aborts).
// Revision    : 1.0 - initial release
// ============================================================================
module exec_flag_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  input  logic [15:0] ER_min,
  input  logic [15:0] ER_max,
  input  logic [15:0] OR_min,
  input  logic [15:0] OR_max,
  input  logic [15:0] data_addr,
  input  logic        data_en,
  input  logic        data_wr,
  input  logic [15:0] dma_addr,
  input  logic        dma_en,
  input  logic        irq,
  input  logic        atom_exec,
  output logic        exec,
  output logic [1:0]  state,
  output logic [2:0]  viol_code,
  output logic [7:0]  abort_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DONE  = 2'b10,
    ST_ABORT = 2'b11
  } state_t;

  localparam logic [2:0] c_CODE_NONE     = 3'd0;
  localparam logic [2:0] c_CODE_ATOM     = 3'd1;
  localparam logic [2:0] c_CODE_CPU_ER   = 3'd2;
  localparam logic [2:0] c_CODE_DMA_ER   = 3'd3;
  localparam logic [2:0] c_CODE_DMA_OR   = 3'd4;
  localparam logic [2:0] c_CODE_IRQ      = 3'd5;
  localparam logic [2:0] c_CODE_MISMATCH = 3'd6;
  localparam logic [2:0] c_CODE_DONE_ACC = 3'd7;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_exec;
  logic [2:0]  r_viol_code;
  logic [7:0]  r_abort_cnt;
  logic        r_last_was_max;
  logic [15:0] r_er_min;
  logic [15:0] r_er_max;
  logic [15:0] r_or_min;
  logic [15:0] r_or_max;

  logic        w_cfg_valid;
  logic        w_entry_ok;
  logic        w_snap_mismatch;
  logic        w_cpu_wr;
  logic        w_data_in_er;
  logic        w_data_in_or;
  logic        w_dma_in_er;
  logic        w_dma_in_or;
  logic        w_pc_in_er;
  logic        w_irq_viol;
  logic        w_enter_run;
  logic        w_enter_abort;
  logic [2:0]  w_viol_code;

  // Regions must be non-empty and disjoint; bounds are inclusive.
  assign w_cfg_valid = (ER_min < ER_max) && (OR_min < OR_max) &&
                       ((ER_max < OR_min) || (OR_max < ER_min));
  assign w_entry_ok  = (pc == ER_min) && w_cfg_valid;

  assign w_snap_mismatch = (ER_min != r_er_min) || (ER_max != r_er_max) ||
                           (OR_min != r_or_min) || (OR_max != r_or_max);

  // Address checks use the captured bounds so a live bound change cannot
  // widen or shrink the protected window mid-run.
  assign w_cpu_wr     = data_en & data_wr;
  assign w_data_in_er = (data_addr >= r_er_min) && (data_addr <= r_er_max);
  assign w_data_in_or = (data_addr >= r_or_min) && (data_addr <= r_or_max);
  assign w_dma_in_er  = (dma_addr  >= r_er_min) && (dma_addr  <= r_er_max);
  assign w_dma_in_or  = (dma_addr  >= r_or_min) && (dma_addr  <= r_or_max);
  assign w_pc_in_er   = (pc        >= r_er_min) && (pc        <= r_er_max);

`ifdef VAPE_IRQ_KILL_EN
  assign w_irq_viol = irq;
`else
  assign w_irq_viol = 1'b0;
  logic w_unused_irq;
  assign w_unused_irq = irq;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_viol_code = c_CODE_NONE;
    case (r_state)
      ST_IDLE: begin
        if (w_entry_ok) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Ordered so the lowest applicable code is the one reported.
        if (!atom_exec)                      w_viol_code = c_CODE_ATOM;
        else if (w_cpu_wr && w_data_in_er)   w_viol_code = c_CODE_CPU_ER;
        else if (dma_en && w_dma_in_er)      w_viol_code = c_CODE_DMA_ER;
        else if (dma_en && w_dma_in_or)      w_viol_code = c_CODE_DMA_OR;
        else if (w_irq_viol)                 w_viol_code = c_CODE_IRQ;
        else if (w_snap_mismatch)            w_viol_code = c_CODE_MISMATCH;

        if (w_viol_code != c_CODE_NONE)
          w_state_nxt = ST_ABORT;
        else if (!w_pc_in_er && r_last_was_max)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (w_snap_mismatch)
          w_viol_code = c_CODE_MISMATCH;
        else if ((w_cpu_wr && (w_data_in_er || w_data_in_or)) ||
                 (dma_en   && (w_dma_in_er  || w_dma_in_or)))
          w_viol_code = c_CODE_DONE_ACC;

        if (w_viol_code != c_CODE_NONE)
          w_state_nxt = ST_ABORT;
        else if (w_entry_ok)
          w_state_nxt = ST_RUN;
      end
      ST_ABORT: begin
        if (w_entry_ok) w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_enter_run   = (w_state_nxt == ST_RUN)   && (r_state != ST_RUN);
  assign w_enter_abort = (w_state_nxt == ST_ABORT) && (r_state != ST_ABORT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_exec         <= 1'b0;
      r_last_was_max <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_exec         <= (w_state_nxt == ST_DONE);
      r_last_was_max <= (pc == ER_max);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_er_min <= 16'h0000;
      r_er_max <= 16'h0000;
      r_or_min <= 16'h0000;
      r_or_max <= 16'h0000;
    end else if (w_enter_run) begin
      r_er_min <= ER_min;
      r_er_max <= ER_max;
      r_or_min <= OR_min;
      r_or_max <= OR_max;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_viol_code <= c_CODE_NONE;
      r_abort_cnt <= 8'h00;
    end else if (w_enter_abort) begin
      r_viol_code <= w_viol_code;
      if (r_abort_cnt != 8'hFF)
        r_abort_cnt <= r_abort_cnt + 8'd1;
    end
  end

  assign exec      = r_exec;
  assign state     = r_state;
  assign viol_code = r_viol_code;
  assign abort_cnt = r_abort_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exec_flag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_flag_ctrl
// Description : Randomized bench for exec_flag_ctrl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_exec_flag_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc, ER_min, ER_max, OR_min, OR_max, data_addr, dma_addr;
  logic        data_en, data_wr, dma_en, irq, atom_exec;
  logic        exec;
  logic [1:0]  state;
  logic [2:0]  viol_code;
  logic [7:0]  abort_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 idle, 1 running, 2 finished, 3 aborted
  int          m_phase;
  logic [15:0] m_snap [4];
  bit          m_prev_max;
  int          m_code;
  int          m_cnt;

  exec_flag_ctrl u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pc        (pc),
    .ER_min    (ER_min),
    .ER_max    (ER_max),
    .OR_min    (OR_min),
    .OR_max    (OR_max),
    .data_addr (data_addr),
    .data_en   (data_en),
    .data_wr   (data_wr),
    .dma_addr  (dma_addr),
    .dma_en    (dma_en),
    .irq       (irq),
    .atom_exec (atom_exec),
    .exec      (exec),
    .state     (state),
    .viol_code (viol_code),
    .abort_cnt (abort_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit inside_rng(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  task automatic model_reset();
    m_phase = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 16'h0;
    m_prev_max = 0;
    m_code = 0;
    m_cnt = 0;
  endtask

  task automatic note_code(inout int lowest, input int c);
    if (lowest == 0 || c < lowest) lowest = c;
  endtask

  // Evaluate one clock edge from the inputs currently applied.
  task automatic model_step();
    bit valid, reenter, changed, cpu_w;
    int lowest = 0;
    int nxt = m_phase;
    valid   = (ER_min < ER_max) && (OR_min < OR_max) &&
              !(ER_min <= OR_max && OR_min <= ER_max);
    reenter = (pc == ER_min) && valid;
    changed = (ER_min != m_snap[0]) || (ER_max != m_snap[1]) ||
              (OR_min != m_snap[2]) || (OR_max != m_snap[3]);
    cpu_w   = data_en && data_wr;
    case (m_phase)
      0: if (reenter) nxt = 1;
      1: begin
        if (!atom_exec) note_code(lowest, 1);
        if (cpu_w && inside_rng(data_addr, m_snap[0], m_snap[1])) note_code(lowest, 2);
        if (dma_en && inside_rng(dma_addr, m_snap[0], m_snap[1])) note_code(lowest, 3);
        if (dma_en && inside_rng(dma_addr, m_snap[2], m_snap[3])) note_code(lowest, 4);
`ifdef VAPE_IRQ_KILL_EN
        if (irq) note_code(lowest, 5);
`endif
        if (changed) note_code(lowest, 6);
        if (lowest == 0 && m_prev_max && !inside_rng(pc, m_snap[0], m_snap[1])) nxt = 2;
      end
      2: begin
        if (changed) note_code(lowest, 6);
        if (cpu_w && (inside_rng(data_addr, m_snap[0], m_snap[1]) ||
                      inside_rng(data_addr, m_snap[2], m_snap[3]))) note_code(lowest, 7);
        if (dma_en && (inside_rng(dma_addr, m_snap[0], m_snap[1]) ||
                       inside_rng(dma_addr, m_snap[2], m_snap[3]))) note_code(lowest, 7);
        if (lowest == 0 && reenter) nxt = 1;
      end
      default: if (reenter) nxt = 1;
    endcase
    if (lowest != 0) begin
      nxt = 3;
      m_code = lowest;
      if (m_cnt < 255) m_cnt++;
    end
    if (nxt == 1 && m_phase != 1) begin
      m_snap[0] = ER_min; m_snap[1] = ER_max; m_snap[2] = OR_min; m_snap[3] = OR_max;
    end
    m_prev_max = (pc == ER_max);
    m_phase = nxt;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_val("state", 16'(state), 16'(m_phase));
    check_val("exec", 16'(exec), 16'(m_phase == 2));
    check_val("viol_code", 16'(viol_code), 16'(m_code));
    check_val("abort_cnt", 16'(abort_cnt), 16'(m_cnt));
  endtask

  task automatic quiet_inputs();
    ER_min = 16'hE000; ER_max = 16'hE0FF; OR_min = 16'h0300; OR_max = 16'h03FF;
    data_addr = 16'h0000; data_en = 0; data_wr = 0;
    dma_addr = 16'h0000; dma_en = 0; irq = 0; atom_exec = 1;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 2))
      0:       return 16'hE000 + 16'($urandom_range(0, 255));
      1:       return 16'h0300 + 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_inputs();
    int r;
    quiet_inputs();
    case ($urandom_range(0, 5))
      0:       pc = 16'hE000;
      1:       pc = 16'hE0FF;
      2, 3:    pc = 16'hE000 + 16'($urandom_range(1, 254));
      4:       pc = 16'h1234;
      default: pc = 16'($urandom);
    endcase
    atom_exec = ($urandom_range(0, 29) != 0);
    data_en   = ($urandom_range(0, 7) == 0);
    data_wr   = 1'($urandom_range(0, 1));
    data_addr = pick_addr();
    dma_en    = ($urandom_range(0, 11) == 0);
    dma_addr  = pick_addr();
    irq       = ($urandom_range(0, 19) == 0);
    r = $urandom_range(0, 99);
    if (r == 0) ER_max = 16'hE1FF;
    else if (r == 1) OR_min = 16'h0200;
    else if (r == 2) ER_min = 16'hE001;
    else if (r == 3) OR_min = 16'hE080;
  endtask

  task automatic run_to_done();
    pc = 16'hE000; step();
    pc = 16'hE002; step();
    pc = 16'hE0FE; step();
    pc = 16'hE0FF; step();
    pc = 16'h1234; step();
  endtask

  initial begin
    reset_n = 0;
    pc = 16'h0000;
    quiet_inputs();
    model_reset();
    #12;
    check_val("rst_state", 16'(state), 16'h0);
    check_val("rst_exec", 16'(exec), 16'h0);
    check_val("rst_viol", 16'(viol_code), 16'h0);
    check_val("rst_cnt", 16'(abort_cnt), 16'h0);
    reset_n = 1;

    // CPU write into ER mid-run
    pc = 16'h1000; step();
    pc = 16'hE000; step();
    pc = 16'hE002; step();
    pc = 16'hE050; data_en = 1; data_wr = 1; data_addr = 16'hE010; step();
    check_val("wr_er_state", 16'(state), 16'h3);
    check_val("wr_er_code", 16'(viol_code), 16'h2);
    check_val("wr_er_cnt", 16'(abort_cnt), 16'h1);
    check_val("wr_er_exec", 16'(exec), 16'h0);
    quiet_inputs();

    // Clean run, exec one cycle after leaving ER
    run_to_done();
    check_val("done_state", 16'(state), 16'h2);
    check_val("done_exec", 16'(exec), 16'h1);

    // DMA into OR while DONE, then re-entry
    dma_en = 1; dma_addr = 16'h0310; step();
    check_val("dma_or_exec", 16'(exec), 16'h0);
    check_val("dma_or_code", 16'(viol_code), 16'h7);
    dma_en = 0; pc = 16'hE000; step();
    check_val("reentry_state", 16'(state), 16'h1);

    // irq during RUN
    pc = 16'hE050; irq = 1; step();
    irq = 0;
`ifdef VAPE_IRQ_KILL_EN
    check_val("irq_code", 16'(viol_code), 16'h5);
`else
    pc = 16'hE0FF; step();
    pc = 16'h1234; step();
    check_val("irq_exec", 16'(exec), 16'h1);
`endif

    // Bound change and atom drop in the same cycle
    pc = 16'hE000; step();
    pc = 16'hE020; ER_max = 16'hE1FF; atom_exec = 0; step();
    check_val("lowest_code", 16'(viol_code), 16'h1);
    quiet_inputs();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end
    quiet_inputs();

    // Saturating abort counter
    for (int i = 0; i < 300; i++) begin
      pc = 16'hE000; atom_exec = 1; step();
      atom_exec = 0; step();
    end
    atom_exec = 1;
    check_val("cnt_sat", 16'(abort_cnt), 16'h00FF);

    // Asynchronous reset while DONE
    run_to_done();
    check_val("pre_rst_exec", 16'(exec), 16'h1);
    #1 reset_n = 0;
    #1;
    check_val("async_exec", 16'(exec), 16'h0);
    check_val("async_cnt", 16'(abort_cnt), 16'h0);
    check_val("async_state", 16'(state), 16'h0);
    model_reset();
    #1 reset_n = 1;
    pc = 16'hE000; step();
    check_val("post_rst_run", 16'(state), 16'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
